// File: rtl/dcache_pkg.sv
// Shared state encoding and address helpers for the N-way D-cache data array.
package dcache_pkg;

   typedef enum logic [2:0] {IDLE, REFILL, EV_RD, EV_OUT, DONE} state_e;

   localparam int DEF_WAYS       = 2;
   localparam int DEF_SETS       = 32;
   localparam int DEF_LINE_BYTES = 64;
   localparam int DEF_BANK_W     = 128;
   localparam int DEF_BEAT_W     = 64;

   // Beat counter must be able to hold BEATS itself, hence the extra bit.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic logic [31:0] bank_addr(input logic [31:0] index,
                                             input logic [31:0] word,
                                             input int          wsel_w);
      return (index << wsel_w) | word;
   endfunction

endpackage

// File: rtl/dcache_data_bank.sv
// Single-port byte-writable SRAM bank with one-cycle synchronous read.
// Behavioural model; replaced by the foundry macro at synthesis.
module dcache_data_bank #(
   parameter  int DEPTH = 128,
   parameter  int WIDTH = 128,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               en_i,
   input  logic               we_i,
   input  logic [AW-1:0]      addr_i,
   input  logic [WIDTH/8-1:0] be_i,
   input  logic [WIDTH-1:0]   wdata_i,
   output logic [WIDTH-1:0]   rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < WIDTH/8; b++) begin
               if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_data_array_nway.sv
// N-way D-cache data store: hit reads, byte-masked stores, AXI line refill
// and dirty-victim streaming, one SRAM access per cycle.
module dcache_data_array_nway
   import dcache_pkg::*;
#(
   parameter  int WAYS       = DEF_WAYS,
   parameter  int SETS       = DEF_SETS,
   parameter  int LINE_BYTES = DEF_LINE_BYTES,
   parameter  int BANK_W     = DEF_BANK_W,
   parameter  int BEAT_W     = DEF_BEAT_W,
   localparam int IDX_W      = $clog2(SETS),
   localparam int WAY_W      = $clog2(WAYS),
   localparam int WSEL_W     = $clog2(LINE_BYTES*8/BANK_W)
) (
   input  logic                   clk,
   input  logic                   rrst_n,
   input  logic                   rd_en,
   input  logic [IDX_W-1:0]       rd_index,
   input  logic [WSEL_W-1:0]      rd_word,
   output logic                   rd_valid,
   output logic [WAYS*BANK_W-1:0] rd_data,
   input  logic                   st_en,
   input  logic [WAY_W-1:0]       st_way,
   input  logic [IDX_W-1:0]       st_index,
   input  logic [WSEL_W-1:0]      st_word,
   input  logic [BANK_W/8-1:0]    st_mask,
   input  logic [BANK_W-1:0]      st_data,
   input  logic                   refill_start,
   input  logic [WAY_W-1:0]       refill_way,
   input  logic [IDX_W-1:0]       refill_index,
   input  logic                   refill_valid,
   input  logic [BEAT_W-1:0]      refill_data,
   output logic                   refill_ready,
   output logic                   refill_done,
   input  logic                   evict_start,
   input  logic [WAY_W-1:0]       evict_way,
   input  logic [IDX_W-1:0]       evict_index,
   output logic                   evict_valid,
   output logic [BEAT_W-1:0]      evict_data,
   input  logic                   evict_ready,
   output logic                   evict_done,
   output logic                   busy
);

   localparam int unsigned BPB   = BANK_W / BEAT_W;
   localparam int unsigned BEATS = LINE_BYTES * 8 / BEAT_W;
   localparam int          CW    = cnt_w(BEATS);
   localparam int          DEPTH = SETS * (LINE_BYTES * 8 / BANK_W);
   localparam int          AW    = IDX_W + WSEL_W;

   state_e              state_q, state_d;
   logic [CW-1:0]       beat_q, beat_d, beat_inc;
   logic [WAY_W-1:0]    way_q, way_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                ev_q, ev_d, cap_q, cap_d, rd_vld_q, rd_vld_d;
   logic [BANK_W-1:0]   asm_q, asm_d, hold_q, ev_word;
   int unsigned         pos;
   logic [WSEL_W-1:0]   cur_word;
   logic                word_last, line_last, rf_hs;

   logic [WAYS-1:0]     bank_en;
   logic                bank_we;
   logic [AW-1:0]       bank_a;
   logic [BANK_W/8-1:0] bank_be;
   logic [BANK_W-1:0]   bank_wd;
   logic [BANK_W-1:0]   bank_rd [WAYS];

   assign pos       = 32'(beat_q) % BPB;
   assign cur_word  = WSEL_W'(32'(beat_q) / BPB);
   assign beat_inc  = beat_q + CW'(1);
   assign word_last = (pos == BPB - 1);
   assign line_last = (beat_inc == CW'(BEATS));
   assign rf_hs     = (state_q == REFILL) && refill_valid;

   // Current beat merged into the partially assembled bank word.
   always_comb begin
      asm_d = asm_q;
      asm_d[pos*BEAT_W +: BEAT_W] = refill_data;
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      way_d    = way_q;
      idx_d    = idx_q;
      ev_d     = ev_q;
      cap_d    = 1'b0;
      rd_vld_d = 1'b0;
      bank_en  = '0;
      bank_we  = 1'b0;
      bank_a   = '0;
      bank_be  = '0;
      bank_wd  = asm_d;
      case (state_q)
         IDLE: begin
            if (refill_start) begin
               state_d = REFILL;
               way_d   = refill_way;
               idx_d   = refill_index;
               beat_d  = '0;
               ev_d    = 1'b0;
            end else if (evict_start) begin
               state_d = EV_RD;
               way_d   = evict_way;
               idx_d   = evict_index;
               beat_d  = '0;
               ev_d    = 1'b1;
            end else if (st_en) begin
               bank_en[st_way] = 1'b1;
               bank_we = 1'b1;
               bank_be = st_mask;
               bank_wd = st_data;
               bank_a  = AW'(bank_addr(32'(st_index), 32'(st_word), WSEL_W));
            end else if (rd_en) begin
               bank_en  = '1;
               bank_a   = AW'(bank_addr(32'(rd_index), 32'(rd_word), WSEL_W));
               rd_vld_d = 1'b1;
            end
         end
         REFILL: begin
            if (refill_valid) begin
               beat_d = beat_inc;
               if (word_last) begin
                  bank_en[way_q] = 1'b1;
                  bank_we = 1'b1;
                  bank_be = '1;
                  bank_a  = AW'(bank_addr(32'(idx_q), 32'(cur_word), WSEL_W));
               end
               if (line_last) state_d = DONE;
            end
         end
         EV_RD: begin
            bank_en[way_q] = 1'b1;
            bank_a  = AW'(bank_addr(32'(idx_q), 32'(cur_word), WSEL_W));
            cap_d   = 1'b1;
            state_d = EV_OUT;
         end
         EV_OUT: begin
            if (evict_ready) begin
               beat_d = beat_inc;
               if (word_last) state_d = line_last ? DONE : EV_RD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         way_q    <= '0;
         idx_q    <= '0;
         ev_q     <= 1'b0;
         cap_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         way_q    <= way_d;
         idx_q    <= idx_d;
         ev_q     <= ev_d;
         cap_q    <= cap_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   // The bank output is only valid the cycle after EV_RD, so it is held here.
   always_ff @(posedge clk) begin
      if (rf_hs) asm_q <= asm_d;
      if (cap_q) hold_q <= bank_rd[way_q];
   end

   assign ev_word = cap_q ? bank_rd[way_q] : hold_q;

   always_comb begin
      evict_data = '0;
      if (state_q == EV_OUT) evict_data = ev_word[pos*BEAT_W +: BEAT_W];
   end

   assign rd_valid     = rd_vld_q;
   assign refill_ready = (state_q == REFILL);
   assign refill_done  = (state_q == DONE) && !ev_q;
   assign evict_valid  = (state_q == EV_OUT);
   assign evict_done   = (state_q == DONE) && ev_q;
   assign busy         = (state_q != IDLE);

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      dcache_data_bank #(
         .DEPTH (DEPTH),
         .WIDTH (BANK_W)
      ) u_bank (
         .clk_i   (clk),
         .en_i    (bank_en[w]),
         .we_i    (bank_we),
         .addr_i  (bank_a),
         .be_i    (bank_be),
         .wdata_i (bank_wd),
         .rdata_o (bank_rd[w])
      );
      assign rd_data[w*BANK_W +: BANK_W] = bank_rd[w];
   end

endmodule

// File: tb/tb_dcache_data_array_nway.sv
// Directed bench for dcache_data_array_nway: default 2-way build plus a
// 4-way, one-beat-per-bank build.
module tb_dcache_data_array_nway;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rrst_n;

   logic         rd_en, rd_valid;
   logic [4:0]   rd_index;
   logic [1:0]   rd_word;
   logic [255:0] rd_data;
   logic         st_en, st_way;
   logic [4:0]   st_index;
   logic [1:0]   st_word;
   logic [15:0]  st_mask;
   logic [127:0] st_data;
   logic         refill_start, refill_way, refill_valid, refill_ready, refill_done;
   logic [4:0]   refill_index;
   logic [63:0]  refill_data;
   logic         evict_start, evict_way, evict_valid, evict_ready, evict_done, busy;
   logic [4:0]   evict_index;
   logic [63:0]  evict_data;

   logic         b_rd_en, b_rd_valid;
   logic [5:0]   b_rd_index;
   logic [2:0]   b_rd_word;
   logic [255:0] b_rd_data;
   logic         b_st_en;
   logic [1:0]   b_st_way;
   logic [5:0]   b_st_index;
   logic [2:0]   b_st_word;
   logic [7:0]   b_st_mask;
   logic [63:0]  b_st_data;
   logic         b_refill_start, b_refill_valid, b_refill_ready, b_refill_done;
   logic [1:0]   b_refill_way;
   logic [5:0]   b_refill_index;
   logic [63:0]  b_refill_data;
   logic         b_evict_start, b_evict_valid, b_evict_ready, b_evict_done, b_busy;
   logic [1:0]   b_evict_way;
   logic [5:0]   b_evict_index;
   logic [63:0]  b_evict_data;

   dcache_data_array_nway u_dut (
      .clk(clk), .rrst_n(rrst_n),
      .rd_en(rd_en), .rd_index(rd_index), .rd_word(rd_word),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .st_en(st_en), .st_way(st_way), .st_index(st_index), .st_word(st_word),
      .st_mask(st_mask), .st_data(st_data),
      .refill_start(refill_start), .refill_way(refill_way), .refill_index(refill_index),
      .refill_valid(refill_valid), .refill_data(refill_data),
      .refill_ready(refill_ready), .refill_done(refill_done),
      .evict_start(evict_start), .evict_way(evict_way), .evict_index(evict_index),
      .evict_valid(evict_valid), .evict_data(evict_data),
      .evict_ready(evict_ready), .evict_done(evict_done), .busy(busy)
   );

   dcache_data_array_nway #(
      .WAYS(4), .SETS(64), .LINE_BYTES(64), .BANK_W(64), .BEAT_W(64)
   ) u_dut4 (
      .clk(clk), .rrst_n(rrst_n),
      .rd_en(b_rd_en), .rd_index(b_rd_index), .rd_word(b_rd_word),
      .rd_valid(b_rd_valid), .rd_data(b_rd_data),
      .st_en(b_st_en), .st_way(b_st_way), .st_index(b_st_index), .st_word(b_st_word),
      .st_mask(b_st_mask), .st_data(b_st_data),
      .refill_start(b_refill_start), .refill_way(b_refill_way), .refill_index(b_refill_index),
      .refill_valid(b_refill_valid), .refill_data(b_refill_data),
      .refill_ready(b_refill_ready), .refill_done(b_refill_done),
      .evict_start(b_evict_start), .evict_way(b_evict_way), .evict_index(b_evict_index),
      .evict_valid(b_evict_valid), .evict_data(b_evict_data),
      .evict_ready(b_evict_ready), .evict_done(b_evict_done), .busy(b_busy)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit           st;
      logic         way;
      logic [4:0]   idx;
      logic [1:0]   word;
      logic [15:0]  mask;
      logic [127:0] data;
      logic [255:0] exp;
   } vec_t;

   vec_t vt [7];

   function automatic logic [63:0] w1(input int k);
      return 64'hC0DE_0000_0000_1000 + 64'(k);
   endfunction

   function automatic logic [63:0] w0(input int k);
      return 64'hBEEF_0000_0000_2000 + 64'(k);
   endfunction

   function automatic logic [63:0] bb(input int w, input int k);
      return 64'h4000_0000_0000_0000 + 64'(w * 256 + k);
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_refill_start(input logic w, input logic [4:0] idx);
      refill_start = 1'b1;
      refill_way   = w;
      refill_index = idx;
      step();
      refill_start = 1'b0;
   endtask

   task automatic a_beats(input logic [63:0] base, input bit toggle, input int n);
      for (int k = 0; k < n; k++) begin
         if (toggle) begin
            refill_valid = 1'b0;
            step();
            chk("refill_stall_ready", refill_ready, 1);
         end
         refill_valid = 1'b1;
         refill_data  = base + 64'(k);
         chk("refill_ready", refill_ready, 1);
         chk("refill_done_early", refill_done, 0);
         step();
         refill_valid = 1'b0;
      end
   endtask

   task automatic a_refill_finish();
      chk("refill_done", refill_done, 1);
      chk("refill_ready_done", refill_ready, 0);
      step();
      chk("refill_done_pulse", refill_done, 0);
      chk("refill_busy_idle", busy, 0);
   endtask

   task automatic a_read(input logic [4:0] idx, input logic [1:0] word, output logic [255:0] d);
      rd_en    = 1'b1;
      rd_index = idx;
      rd_word  = word;
      step();
      rd_en = 1'b0;
      chk("rd_valid", rd_valid, 1);
      d = rd_data;
      step();
      chk("rd_valid_drop", rd_valid, 0);
   endtask

   task automatic a_store(input logic w, input logic [4:0] idx, input logic [1:0] word,
                          input logic [15:0] mask, input logic [127:0] data);
      st_en    = 1'b1;
      st_way   = w;
      st_index = idx;
      st_word  = word;
      st_mask  = mask;
      st_data  = data;
      step();
      st_en = 1'b0;
   endtask

   task automatic b_refill(input logic [1:0] w, input logic [5:0] idx);
      b_refill_start = 1'b1;
      b_refill_way   = w;
      b_refill_index = idx;
      step();
      b_refill_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         b_refill_valid = 1'b1;
         b_refill_data  = bb(int'(w), k);
         step();
      end
      b_refill_valid = 1'b0;
      chk("b_refill_done", b_refill_done, 1);
      step();
   endtask

   task automatic b_read(input logic [5:0] idx, input logic [2:0] word, output logic [255:0] d);
      b_rd_en    = 1'b1;
      b_rd_index = idx;
      b_rd_word  = word;
      step();
      b_rd_en = 1'b0;
      chk("b_rd_valid", b_rd_valid, 1);
      d = b_rd_data;
      step();
   endtask

   logic [255:0] d;

   initial begin
      vt[0] = '{1'b0, 1'b0, 5'd5, 2'd2, 16'h0, 128'h0, {w1(5), w1(4), w0(5), w0(4)}};
      vt[1] = '{1'b0, 1'b0, 5'd5, 2'd0, 16'h0, 128'h0, {w1(1), w1(0), w0(1), w0(0)}};
      vt[2] = '{1'b0, 1'b0, 5'd5, 2'd3, 16'h0, 128'h0, {w1(7), w1(6), w0(7), w0(6)}};
      vt[3] = '{1'b1, 1'b1, 5'd5, 2'd2, 16'h000F, {16{8'hAA}}, 256'h0};
      vt[4] = '{1'b0, 1'b0, 5'd5, 2'd2, 16'h0, 128'h0,
                {w1(5), 64'hC0DE_0000_AAAA_AAAA, w0(5), w0(4)}};
      vt[5] = '{1'b1, 1'b0, 5'd5, 2'd1, 16'hF000, {16{8'h55}}, 256'h0};
      vt[6] = '{1'b0, 1'b0, 5'd5, 2'd1, 16'h0, 128'h0,
                {w1(3), w1(2), 64'h5555_5555_0000_2003, w0(2)}};

      rrst_n = 1'b0;
      {rd_en, st_en, refill_start, refill_valid, evict_start, evict_ready} = '0;
      {rd_index, rd_word, st_way, st_index, st_word, st_mask, st_data} = '0;
      {refill_way, refill_index, refill_data, evict_way, evict_index} = '0;
      {b_rd_en, b_st_en, b_refill_start, b_refill_valid, b_evict_start, b_evict_ready} = '0;
      {b_rd_index, b_rd_word, b_st_way, b_st_index, b_st_word, b_st_mask, b_st_data} = '0;
      {b_refill_way, b_refill_index, b_refill_data, b_evict_way, b_evict_index} = '0;

      repeat (3) step();
      chk("reset_ctrl", {rd_valid, refill_ready, refill_done, evict_valid, evict_done, busy}, 0);
      chk("reset_evict_data", evict_data, 0);
      chk("reset_b_busy", b_busy, 0);
      rrst_n = 1'b1;
      step();

      // Reset asserted part-way through a refill.
      a_refill_start(1'b0, 5'd9);
      a_beats(64'h3000, 1'b0, 3);
      chk("midrst_pre_ready", refill_ready, 1);
      rrst_n = 1'b0;
      #1;
      chk("midrst_ctrl", {rd_valid, refill_ready, refill_done, evict_valid, evict_done, busy}, 0);
      chk("midrst_evict_data", evict_data, 0);
      step();
      rrst_n = 1'b1;
      step();
      a_refill_start(1'b0, 5'd9);
      a_beats(64'h3000, 1'b0, 8);
      a_refill_finish();

      a_refill_start(1'b0, 5'd5);
      a_beats(w0(0), 1'b0, 8);
      a_refill_finish();
      a_refill_start(1'b1, 5'd5);
      a_beats(w1(0), 1'b1, 8);
      a_refill_finish();

      // Victim readout with a three-cycle back-pressure stall on beat 3.
      evict_start = 1'b1;
      evict_way   = 1'b1;
      evict_index = 5'd5;
      step();
      evict_start = 1'b0;
      chk("evict_first_bubble", evict_valid, 0);
      chk("evict_busy", busy, 1);
      for (int k = 0; k < 8; k++) begin
         for (int t = 0; t < 4 && !evict_valid; t++) step();
         chk("evict_valid", evict_valid, 1);
         chk("evict_data", evict_data, w1(k));
         if (k == 3) begin
            repeat (3) begin
               step();
               chk("evict_hold_valid", evict_valid, 1);
               chk("evict_hold_data", evict_data, w1(3));
            end
         end
         chk("evict_done_early", evict_done, 0);
         evict_ready = 1'b1;
         step();
         evict_ready = 1'b0;
         if (k % 2 == 1 && k < 7) chk("evict_word_bubble", evict_valid, 0);
      end
      chk("evict_done", evict_done, 1);
      step();
      chk("evict_done_pulse", evict_done, 0);
      chk("evict_busy_idle", busy, 0);

      for (int i = 0; i < 7; i++) begin
         if (vt[i].st) begin
            a_store(vt[i].way, vt[i].idx, vt[i].word, vt[i].mask, vt[i].data);
         end else begin
            a_read(vt[i].idx, vt[i].word, d);
            chk($sformatf("vec%0d", i), d, vt[i].exp);
         end
      end

      // Same-cycle refill/store/read: only the refill may proceed.
      refill_start = 1'b1; refill_way = 1'b0; refill_index = 5'd7;
      st_en = 1'b1; st_way = 1'b1; st_index = 5'd5; st_word = 2'd2;
      st_mask = 16'hFFFF; st_data = '0;
      rd_en = 1'b1; rd_index = 5'd5; rd_word = 2'd2;
      step();
      refill_start = 1'b0; st_en = 1'b0; rd_en = 1'b0;
      chk("prio_busy", busy, 1);
      chk("prio_refill_ready", refill_ready, 1);
      chk("prio_rd_valid", rd_valid, 0);
      a_beats(64'h7000, 1'b0, 8);
      a_refill_finish();
      a_read(5'd5, 2'd2, d);
      chk("prio_store_dropped", d, vt[4].exp);

      for (int w = 0; w < 4; w++) b_refill(2'(w), 6'd3);
      b_read(6'd3, 3'd5, d);
      chk("b_word5", d, {bb(3, 5), bb(2, 5), bb(1, 5), bb(0, 5)});
      b_read(6'd3, 3'd0, d);
      chk("b_word0", d, {bb(3, 0), bb(2, 0), bb(1, 0), bb(0, 0)});
      b_read(6'd3, 3'd7, d);
      chk("b_word7", d, {bb(3, 7), bb(2, 7), bb(1, 7), bb(0, 7)});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
